fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain.sv | 90 +++++++++
 tb/tb_fifo_drain.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// fifo_drain: pops a burst of words from an upstream FIFO through a 2-entry skid buffer to a ready/valid port.
module fifo_drain #(
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_burst_len,
    input  logic                  i_abort,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] in_fifo,
    output logic                  o_pop,
    output logic                  o_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int CW = LEN_WIDTH + 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [CW-1:0] len, pop_cnt, sent_cnt;
    logic [DATA_WIDTH-1:0] head, tail, head_n, tail_n;
    logic [1:0] cnt, cnt_m, cnt_n, occ;
    logic inflight, hs, accept;
    assign hs = o_valid & i_ready;
    assign accept = state == IDLE && i_start && !i_abort;
    // occupancy the buffer would have if a pop issued now, counting the word in flight
    assign occ = cnt + {1'b0, inflight} - {1'b0, hs};
    assign o_valid = cnt != 2'd0;
    assign o_data = head;
    assign o_last = o_valid && sent_cnt == len - CW'(1);
    assign o_busy = state != IDLE;
    assign o_done = state == DONE;
    assign o_pop = state == RUN && pop_cnt < len && !i_fifo_empty && occ < 2'd2;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = i_start ? RUN : IDLE;
            RUN:     state_n = pop_cnt == len ? DRAIN : RUN;
            DRAIN:   state_n = DRAIN;
            default: state_n = IDLE;
        endcase
        if ((state == RUN || state == DRAIN) && hs && o_last)
            state_n = DONE;
        if (i_abort)
            state_n = IDLE;
    end
    always_comb begin
        head_n = hs ? tail : head;
        tail_n = tail;
        cnt_m = cnt - {1'b0, hs};
        if (inflight && cnt_m == 2'd0)
            head_n = in_fifo;
        else if (inflight)
            tail_n = in_fifo;
        cnt_n = cnt_m + {1'b0, inflight};
    end
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            inflight <= 1'b0;
            head <= '0;
            tail <= '0;
            o_flush <= 1'b0;
            len <= '0;
            pop_cnt <= '0;
            sent_cnt <= '0;
        end else begin
            o_flush <= i_abort;
            cnt <= i_abort ? 2'd0 : cnt_n;
            inflight <= !i_abort && o_pop;
            head <= head_n;
            tail <= tail_n;
            // a zero length field becomes 2^LEN_WIDTH through the extra top bit
            len <= accept ? {i_burst_len == '0, i_burst_len} : len;
            pop_cnt <= accept ? '0 : pop_cnt + CW'(o_pop);
            sent_cnt <= accept ? '0 : sent_cnt + CW'(hs);
        end
    end
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: queue-based FIFO model, scoreboard and monitor for fifo_drain.
module tb_fifo_drain;
    localparam int DW = 16;
    localparam int LW = 4;
    typedef struct packed {logic [DW-1:0] d; logic l;} exp_t;
    logic clk = 0, rst = 1, i_start = 0, i_abort = 0, i_fifo_empty = 1, i_ready = 0;
    logic [LW-1:0] i_burst_len = '0;
    logic [DW-1:0] in_fifo = '0;
    logic o_pop, o_flush, o_valid, o_last, o_busy, o_done;
    logic [DW-1:0] o_data;
    int n_vec = 0, n_err = 0, pops = 0, hs_cnt = 0, done_cnt = 0, cyc_n = 0;
    int h0, d0, n;
    logic [DW-1:0] fq[$], plan[$], later[$];
    exp_t exp_q[$];
    exp_t e;
    int hs_t[$];
    logic pend = 0, rnd_ready = 0;
    logic [DW-1:0] pd = '0;
    logic pv = 0, pr = 0, pl = 0, pc = 1;
    logic [DW-1:0] pdat = '0;

    always #5 clk = ~clk;

    fifo_drain #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_burst_len(i_burst_len),
        .i_abort(i_abort), .i_fifo_empty(i_fifo_empty), .in_fifo(in_fifo),
        .o_pop(o_pop), .o_flush(o_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // one clock: upstream FIFO model answers pops with data one cycle later
    task automatic cyc();
        i_fifo_empty = fq.size() == 0;
        #1;
        pend = 0;
        if (o_pop) begin
            pd = fq.pop_front();
            pend = 1;
            pops++;
        end
        if (o_flush) fq.delete();
        @(posedge clk);
        #1;
        in_fifo = pend ? pd : DW'($urandom);
    endtask

    // reference: a burst delivers the first n words the FIFO will hold, last flag on the nth
    task automatic expect_from(input int cnt);
        exp_t x;
        for (int i = 0; i < cnt; i++) begin
            x.d = plan[i];
            x.l = i == cnt - 1;
            exp_q.push_back(x);
        end
    endtask

    task automatic start(input logic [LW-1:0] lf);
        i_burst_len = lf;
        i_start = 1;
        pops = 0;
        cyc();
        i_start = 0;
    endtask

    task automatic wait_done(input int bound, input string nm);
        int dd = done_cnt;
        int k = 0;
        while (done_cnt == dd && k < bound) begin
            if (later.size() > 0 && $urandom_range(0, 1) == 1) fq.push_back(later.pop_front());
            if (rnd_ready) i_ready = $urandom_range(0, 3) != 0;
            cyc();
            k++;
        end
        cyc();
        cyc();
        chk({nm, "_done_pulses"}, done_cnt - dd, 1);
        chk({nm, "_words_left"}, exp_q.size(), 0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_pop"}, o_pop, 0);
        chk({nm, "_flush"}, o_flush, 0);
        chk({nm, "_valid"}, o_valid, 0);
        chk({nm, "_last"}, o_last, 0);
        chk({nm, "_busy"}, o_busy, 0);
        chk({nm, "_done"}, o_done, 0);
        chk({nm, "_data"}, o_data, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc_n++;
            if (pv && !pr && !pc && !rst) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", o_data, pdat);
                chk("hold_last", o_last, pl);
            end
            if (o_valid && i_ready && !rst) begin
                hs_cnt++;
                hs_t.push_back(cyc_n);
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_word: got %0h, expected no word", o_data);
                end else begin
                    n_vec--;
                    e = exp_q.pop_front();
                    chk("word_data", o_data, e.d);
                    chk("word_last", o_last, e.l);
                end
            end
            if (o_done) done_cnt++;
            pv = o_valid;
            pr = i_ready;
            pl = o_last;
            pdat = o_data;
            pc = rst | i_abort;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) cyc();
        chk_all_zero("reset");
        rst = 0;
        cyc();
        // four words, full rate
        i_ready = 1;
        for (int i = 1; i <= 4; i++) fq.push_back(DW'(i));
        plan = fq;
        expect_from(4);
        h0 = hs_t.size();
        start(4'd4);
        wait_done(50, "t1");
        chk("t1_pops", pops, 4);
        chk("t1_handshakes", hs_t.size() - h0, 4);
        if (hs_t.size() >= h0 + 4) chk("t1_rate", hs_t[h0+3] - hs_t[h0], 3);
        // zero length field means sixteen
        for (int i = 0; i < 16; i++) fq.push_back(DW'(16'h0100 + i));
        plan = fq;
        expect_from(16);
        start(4'd0);
        wait_done(80, "t2");
        chk("t2_pops", pops, 16);
        // downstream backpressure
        for (int i = 0; i < 3; i++) fq.push_back(DW'(16'h0300 + i));
        plan = fq;
        expect_from(3);
        i_ready = 0;
        start(4'd3);
        repeat (5) cyc();
        chk("t3_pops_stalled", pops, 2);
        chk("t3_valid_stalled", o_valid, 1);
        i_ready = 1;
        wait_done(40, "t3");
        chk("t3_pops", pops, 3);
        // FIFO runs empty mid burst
        fq.push_back(16'h0400);
        plan = fq;
        for (int i = 1; i < 4; i++) plan.push_back(DW'(16'h0400 + i));
        expect_from(4);
        start(4'd4);
        repeat (10) cyc();
        chk("t4_pops_empty", pops, 1);
        chk("t4_busy_empty", o_busy, 1);
        chk("t4_pop_empty", o_pop, 0);
        for (int i = 1; i < 4; i++) fq.push_back(DW'(16'h0400 + i));
        wait_done(40, "t4");
        chk("t4_pops", pops, 4);
        // abort after two words
        for (int i = 0; i < 5; i++) fq.push_back(DW'(16'h0500 + i));
        plan = fq;
        expect_from(5);
        start(4'd5);
        h0 = hs_cnt;
        for (int k = 0; k < 20 && hs_cnt - h0 < 2; k++) cyc();
        chk("t5_two_words", hs_cnt - h0, 2);
        d0 = done_cnt;
        i_abort = 1;
        cyc();
        i_abort = 0;
        exp_q.delete();
        chk("t5_flush", o_flush, 1);
        chk("t5_valid", o_valid, 0);
        chk("t5_busy", o_busy, 0);
        cyc();
        chk("t5_flush_one_cycle", o_flush, 0);
        chk("t5_no_done", done_cnt - d0, 0);
        fq.push_back(16'h0550);
        fq.push_back(16'h0551);
        plan = fq;
        expect_from(2);
        start(4'd2);
        wait_done(30, "t5_restart");
        // reset while draining with a full buffer
        fq.push_back(16'h0600);
        fq.push_back(16'h0601);
        plan = fq;
        expect_from(2);
        i_ready = 0;
        start(4'd2);
        repeat (6) cyc();
        chk("t6_busy", o_busy, 1);
        chk("t6_valid", o_valid, 1);
        chk("t6_pops", pops, 2);
        d0 = done_cnt;
        rst = 1;
        cyc();
        chk_all_zero("t6_reset");
        rst = 0;
        exp_q.delete();
        fq.delete();
        cyc();
        chk("t6_no_done", done_cnt - d0, 0);
        // random bursts, random ready and random FIFO arrival
        rnd_ready = 1;
        for (int b = 0; b < 20; b++) begin
            n = $urandom_range(1, 16);
            later.delete();
            for (int i = 0; i < n + int'($urandom_range(0, 2)); i++) later.push_back(DW'($urandom));
            plan = fq;
            foreach (later[i]) plan.push_back(later[i]);
            expect_from(n);
            start(LW'(n));
            wait_done(600, "rnd");
            chk("rnd_pops", pops, n);
            while (later.size() > 0) fq.push_back(later.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
